// File: rtl/id_stage_if.sv
// id_stage_if: fetch-side and decode-side handshake bundle for id_stage
interface id_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 6,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_instr;
    logic [DATA_W-1:0] in_pc;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [5:0]        out_opcode;
    logic [REG_AW-1:0] out_rs;
    logic [REG_AW-1:0] out_rt;
    logic [REG_AW-1:0] out_rd;
    logic [5:0]        out_funct;
    logic [DATA_W-1:0] out_imm;
    logic [DATA_W-1:0] out_pc;
    logic              out_is_load;
    logic [CNT_W-1:0]  bubble_cnt;
    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd,
               out_funct, out_imm, out_pc, out_is_load, bubble_cnt
    );
    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd,
               out_funct, out_imm, out_pc, out_is_load, bubble_cnt
    );
endinterface

// File: rtl/id_stage.sv
// id_stage: decode stage with load-use bubble insertion ahead of the register file
module id_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 6,
    parameter int CNT_W  = 16
) (
    input logic     clk,
    input logic     rst_n,
    id_stage_if.slave bus
);
    logic [5:0]        opc;
    logic [4:0]        rs5, rt5, rd5;
    logic [REG_AW-1:0] rs, rt, rd;
    logic [DATA_W-1:0] imm;
    logic              reads_rt, is_lw, hazard, adv, acc;
    logic              ld_pend;
    logic [REG_AW-1:0] ld_dst;
    logic              unused_bits;
    assign unused_bits = ^bus.in_instr[10:6];
    always_comb begin
        opc      = bus.in_instr[31:26];
        rs5      = bus.in_instr[25:21];
        rt5      = bus.in_instr[20:16];
        rd5      = opc == 6'h00 ? bus.in_instr[15:11] : opc == 6'h02 ? 5'd0 : opc == 6'h03 ? 5'd31 : rt5;
        rs       = REG_AW'(rs5);
        rt       = REG_AW'(rt5);
        rd       = REG_AW'(rd5);
        imm      = opc inside {6'h0C, 6'h0D, 6'h0E} ? DATA_W'(bus.in_instr[15:0]) : DATA_W'($signed(bus.in_instr[15:0]));
        reads_rt = opc inside {6'h00, 6'h04, 6'h05, 6'h2B};
        is_lw    = opc == 6'h23;
        // ld_dst is never 0 while ld_pend is set, so $0 cannot stall
        hazard   = bus.in_valid && ld_pend && (rs == ld_dst || (reads_rt && rt == ld_dst));
        adv      = !bus.out_valid || bus.out_ready;
        acc      = bus.in_valid && !bus.flush && !hazard && adv;
        bus.in_ready = !bus.flush && !hazard && adv;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid   <= 1'b0;
            bus.out_opcode  <= '0;
            bus.out_rs      <= '0;
            bus.out_rt      <= '0;
            bus.out_rd      <= '0;
            bus.out_funct   <= '0;
            bus.out_imm     <= '0;
            bus.out_pc      <= '0;
            bus.out_is_load <= 1'b0;
            bus.bubble_cnt  <= '0;
            ld_pend         <= 1'b0;
            ld_dst          <= '0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
            ld_pend       <= 1'b0;
        end else if (adv) begin
            bus.out_valid <= acc;
            ld_pend       <= acc && is_lw && rt5 != 5'd0;
            ld_dst        <= rt;
            if (hazard && bus.bubble_cnt != '1) bus.bubble_cnt <= bus.bubble_cnt + 1'b1;
            if (acc) begin
                bus.out_opcode  <= opc;
                bus.out_rs      <= rs;
                bus.out_rt      <= rt;
                bus.out_rd      <= rd;
                bus.out_funct   <= bus.in_instr[5:0];
                bus.out_imm     <= imm;
                bus.out_pc      <= bus.in_pc;
                bus.out_is_load <= is_lw;
            end
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: randomized scoreboard bench for id_stage against a transaction-level model
module tb_id_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    id_stage_if #(.DATA_W(32), .REG_AW(6), .CNT_W(16)) bus ();
    id_stage #(.DATA_W(32), .REG_AW(6), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic [5:0]  opc;
        logic [5:0]  rs, rt, rd, funct;
        logic [31:0] imm, pc;
        logic        ld;
    } dec_t;

    dec_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] pc_ctr = 32'h1000;
    logic        took;

    logic        m_ov, m_pend;
    logic [4:0]  m_dst;
    logic [15:0] m_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic dec_t decode(input logic [31:0] i, input logic [31:0] pc);
        dec_t d;
        int   op;
        op      = int'(i[31:26]);
        d.opc   = i[31:26];
        d.rs    = {1'b0, i[25:21]};
        d.rt    = {1'b0, i[20:16]};
        case (op)
            0:       d.rd = {1'b0, i[15:11]};
            2:       d.rd = 6'd0;
            3:       d.rd = 6'd31;
            default: d.rd = {1'b0, i[20:16]};
        endcase
        d.funct = i[5:0];
        if (op == 12 || op == 13 || op == 14) d.imm = {16'h0000, i[15:0]};
        else d.imm = {{16{i[15]}}, i[15:0]};
        d.pc    = pc;
        d.ld    = (op == 35);
        return d;
    endfunction

    // Reference model: one output slot; a pending lw result blocks any reader for one slot.
    always @(negedge clk) begin : model
        logic adv, haz, rdy, uses_rt, accepted;
        logic [4:0] irs, irt;
        int op;
        if (!rst_n) begin
            m_ov = 1'b0; m_pend = 1'b0; m_dst = 5'd0; m_cnt = 16'd0;
            exp_q.delete();
        end else begin
            op      = int'(bus.in_instr[31:26]);
            irs     = bus.in_instr[25:21];
            irt     = bus.in_instr[20:16];
            uses_rt = (op == 0 || op == 4 || op == 5 || op == 43);
            adv     = !m_ov || bus.out_ready;
            haz     = bus.in_valid && m_pend && (irs == m_dst || (uses_rt && irt == m_dst));
            rdy     = !bus.flush && !haz && adv;
            chk("in_ready", 32'(bus.in_ready), 32'(rdy));
            chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
            chk("bubble_cnt", 32'(bus.bubble_cnt), 32'(m_cnt));
            if (bus.flush) begin
                m_ov = 1'b0; m_pend = 1'b0;
            end else if (adv) begin
                accepted = bus.in_valid && rdy;
                if (haz && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                m_ov   = accepted;
                m_pend = accepted && op == 35 && irt != 5'd0;
                m_dst  = irt;
                if (accepted) exp_q.push_back(decode(bus.in_instr, bus.in_pc));
            end
        end
    end

    always @(negedge clk) begin : monitor
        dec_t e;
        if (rst_n && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL out_unexpected: got output pc %h want none at %0t", bus.out_pc, $time);
            end else begin
                e = exp_q[0];
                chk("out_opcode", 32'(bus.out_opcode), 32'(e.opc));
                chk("out_rs", 32'(bus.out_rs), 32'(e.rs));
                chk("out_rt", 32'(bus.out_rt), 32'(e.rt));
                chk("out_rd", 32'(bus.out_rd), 32'(e.rd));
                chk("out_funct", 32'(bus.out_funct), 32'(e.funct));
                chk("out_imm", bus.out_imm, e.imm);
                chk("out_pc", bus.out_pc, e.pc);
                chk("out_is_load", 32'(bus.out_is_load), 32'(e.ld));
                if (bus.out_ready || bus.flush) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] ins, input logic fl);
        bus.in_valid = v;
        bus.in_instr = ins;
        bus.in_pc    = pc_ctr;
        bus.flush    = fl;
        pc_ctr       = pc_ctr + 32'd4;
        @(negedge clk);
        took = v && bus.in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, output int stalls);
        stalls = 0;
        step(1'b1, ins, 1'b0);
        while (!took && stalls < 20) begin
            stalls++;
            step(1'b1, ins, 1'b0);
        end
        bus.in_valid = 1'b0;
    endtask

    localparam logic [31:0] ADD  = 32'h00221820;
    localparam logic [31:0] LW4  = 32'h8C240000;
    localparam logic [31:0] DEP4 = 32'h00823020;

    initial begin
        int          s;
        logic [15:0] c0;
        logic [31:0] ins;
        logic [5:0]  ops[11] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B};
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.flush = 1'b0; bus.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_bubble_cnt", 32'(bus.bubble_cnt), 32'd0);
        chk("rst_out_imm", bus.out_imm, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(ADD, s);
        chk("add_valid", 32'(bus.out_valid), 32'd1);
        chk("add_rs", 32'(bus.out_rs), 32'd1);
        chk("add_rt", 32'(bus.out_rt), 32'd2);
        chk("add_rd", 32'(bus.out_rd), 32'd3);
        chk("add_funct", 32'(bus.out_funct), 32'h20);
        send(32'h2005FFFF, s);
        chk("addi_rd", 32'(bus.out_rd), 32'd5);
        chk("addi_imm", bus.out_imm, 32'hFFFFFFFF);
        send(32'h3405FFFF, s);
        chk("ori_imm", bus.out_imm, 32'h0000FFFF);
        send(32'h0C000010, s);
        chk("jal_rd", 32'(bus.out_rd), 32'd31);
        c0 = bus.bubble_cnt;
        send(LW4, s);
        chk("lw_stalls", 32'(s), 32'd0);
        send(DEP4, s);
        chk("loaduse_stalls", 32'(s), 32'd1);
        chk("loaduse_cnt", 32'(bus.bubble_cnt), 32'(c0 + 16'd1));
        chk("loaduse_rd", 32'(bus.out_rd), 32'd6);
        c0 = bus.bubble_cnt;
        send(32'h8C200000, s);
        send(32'h00023020, s);
        chk("lw0_stalls", 32'(s), 32'd0);
        chk("lw0_cnt", 32'(bus.bubble_cnt), 32'(c0));
        step(1'b0, '0, 1'b0);
        bus.out_ready = 1'b0;
        step(1'b1, ADD, 1'b0);
        chk("bp_first_taken", 32'(took), 32'd1);
        repeat (3) begin
            step(1'b1, 32'h00432020, 1'b0);
            chk("bp_blocked", 32'(took), 32'd0);
        end
        bus.out_ready = 1'b1;
        send(32'h00432020, s);
        chk("bp_release_stalls", 32'(s), 32'd0);
        send(LW4, s);
        c0 = bus.bubble_cnt;
        step(1'b0, '0, 1'b1);
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        send(DEP4, s);
        chk("flush_dep_stalls", 32'(s), 32'd0);
        chk("flush_dep_cnt", 32'(bus.bubble_cnt), 32'(c0));
        send(LW4, s);
        step(1'b1, DEP4, 1'b1);
        chk("flushhaz_taken", 32'(took), 32'd0);
        send(DEP4, s);
        chk("flushhaz_stalls", 32'(s), 32'd0);
        chk("flushhaz_cnt", 32'(bus.bubble_cnt), 32'(c0));
        send(LW4, s);
        bus.out_ready = 1'b0;
        repeat (2) step(1'b1, DEP4, 1'b0);
        chk("bphaz_cnt", 32'(bus.bubble_cnt), 32'(c0));
        bus.out_ready = 1'b1;
        send(DEP4, s);
        chk("bphaz_stalls", 32'(s), 32'd1);
        chk("bphaz_cnt_after", 32'(bus.bubble_cnt), 32'(c0 + 16'd1));
        send(ADD, s);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_cnt", 32'(bus.bubble_cnt), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3000) begin
            bus.out_ready = $urandom_range(3) != 0;
            ins = $urandom;
            ins[31:26] = ops[$urandom_range(10)];
            ins[25:21] = 5'($urandom_range(3));
            ins[20:16] = 5'($urandom_range(3));
            ins[15:11] = 5'($urandom_range(3));
            step(1'($urandom_range(1)), ins, $urandom_range(15) == 0);
        end
        bus.out_ready = 1'b1;
        repeat (4) step(1'b0, '0, 1'b0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
